// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
//   Byte-addressable data memory for the CPU load/store path. Four byte-lane
//   arrays (one per byte of a 32-bit word) so that synthesis maps them onto a
//   byte-write-enable block RAM with a registered synchronous read.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   req_valid     request present
//   req_ready     request accepted when high together with req_valid (low only during rst)
//   req_we        1 = store, 0 = load
//   req_size      0 = byte, 1 = half, 2 = word, 3 = reserved
//   req_unsigned  loads only: 1 = zero-extend, 0 = sign-extend
//   req_addr      byte address
//   req_wdata     right-aligned store data
//   resp_valid    one-cycle response pulse, the cycle after acceptance
//   resp_rdata    extended load data; 0 for stores and errors
//   resp_err      misaligned / out-of-range / reserved-size access, no side effect
//
// The memory contents start undefined; nothing is preloaded into the byte lanes.
module data_memory_ctrl #(
    parameter int          ADDR_WIDTH = 18,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter              INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

    logic [31:0]           offset_s;
    logic                  out_of_range_s;
    logic [ADDR_WIDTH-3:0] index_s;
    logic [1:0]            lane_s;
    logic                  accept_s;
    logic                  misalign_s;
    logic                  err_s;
    logic [3:0]            be_s;
    logic [31:0]           wdata_rep_s;
    logic [3:0]            wen_s;
    logic                  rd_en_s;
    logic [31:0]           rd_word_s;
    logic [31:0]           load_data_s;

    logic                  valid_r;
    logic                  err_r;
    logic                  we_r;
    logic [1:0]            size_r;
    logic [1:0]            lane_r;
    logic                  unsigned_r;

    // No response backpressure: the port only refuses requests while in reset.
    assign req_ready = ~rst;
    assign accept_s  = req_valid & ~rst;

    // Address decode relative to BASE_ADDR; the 33-bit compare keeps the range
    // check correct even when ADDR_WIDTH is 32.
    assign offset_s       = req_addr - BASE_ADDR;
    assign out_of_range_s = ({1'b0, offset_s} >= (33'd1 << ADDR_WIDTH));
    assign index_s        = offset_s[ADDR_WIDTH-1:2];
    assign lane_s         = offset_s[1:0];

    // Alignment, lane enables and lane-replicated store data per access size.
    always_comb begin
        misalign_s  = 1'b1;
        be_s        = 4'b0000;
        wdata_rep_s = 32'h0000_0000;
        case (req_size)
            2'd0: begin
                misalign_s  = 1'b0;
                be_s        = 4'b0001 << lane_s;
                wdata_rep_s = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                misalign_s  = lane_s[0];
                be_s        = 4'b0011 << lane_s;
                wdata_rep_s = {2{req_wdata[15:0]}};
            end
            2'd2: begin
                misalign_s  = (lane_s != 2'd0);
                be_s        = 4'b1111;
                wdata_rep_s = req_wdata;
            end
            default: begin
                misalign_s  = 1'b1;
                be_s        = 4'b0000;
                wdata_rep_s = 32'h0000_0000;
            end
        endcase
    end

    assign err_s   = misalign_s | out_of_range_s;
    assign wen_s   = (accept_s & req_we & ~err_s) ? be_s : 4'b0000;
    assign rd_en_s = accept_s & ~req_we & ~err_s;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_byte_r;

            // Byte-lane RAM: write on enabled lane, registered read on loads.
            always_ff @(posedge clk) begin
                if (wen_s[g]) begin
                    lane_mem[index_s] <= wdata_rep_s[8*g +: 8];
                end
                if (rd_en_s) begin
                    rd_byte_r <= lane_mem[index_s];
                end
            end
        end
    endgenerate

    assign rd_word_s = {g_lane[3].rd_byte_r, g_lane[2].rd_byte_r,
                        g_lane[1].rd_byte_r, g_lane[0].rd_byte_r};

    // Response pipeline stage: remembers what the accepted access needs to
    // turn the raw RAM word into the returned value.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
            we_r       <= 1'b0;
            size_r     <= 2'd0;
            lane_r     <= 2'd0;
            unsigned_r <= 1'b0;
        end else begin
            valid_r    <= accept_s;
            err_r      <= err_s;
            we_r       <= req_we;
            size_r     <= req_size;
            lane_r     <= lane_s;
            unsigned_r <= req_unsigned;
        end
    end

    // Lane select and sign/zero extension of the registered RAM word.
    always_comb begin
        logic [7:0]  sel_byte;
        logic [15:0] sel_half;
        sel_byte    = rd_word_s[{lane_r, 3'b000} +: 8];
        sel_half    = rd_word_s[{lane_r[1], 4'b0000} +: 16];
        load_data_s = 32'h0000_0000;
        case (size_r)
            2'd0:    load_data_s = {{24{sel_byte[7] & ~unsigned_r}}, sel_byte};
            2'd1:    load_data_s = {{16{sel_half[15] & ~unsigned_r}}, sel_half};
            2'd2:    load_data_s = rd_word_s;
            default: load_data_s = 32'h0000_0000;
        endcase
    end

    // A response falling in a reset cycle is dropped.
    assign resp_valid = valid_r & ~rst;
    assign resp_err   = valid_r & ~rst & err_r;
    assign resp_rdata = (valid_r & ~rst & ~err_r & ~we_r) ? load_data_s : 32'h0000_0000;

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;

    localparam int          AW   = 18;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    data_memory_ctrl #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .INIT_FILE("")) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        has_lit;
        logic [31:0] lit;
        logic        lit_err;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  mmem [int];     // model memory: byte offset -> byte
    int          checks   = 0;
    int          failures = 0;
    logic        acc_prev = 1'b0;
    exp_t        cur;
    logic        exp_valid;

    // Was a request accepted at the last rising edge?
    always @(posedge clk) acc_prev <= req_valid & ~rst;

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        exp_valid = acc_prev & ~rst;
        if (acc_prev) begin
            if (expq.size() > 0) begin
                cur = expq.pop_front();
            end else if (exp_valid) begin
                failures++;
                $display("FAIL scoreboard_empty: response expected but no model entry");
            end
        end
        checks++;
        if (req_ready !== ~rst) begin
            failures++;
            $display("FAIL req_ready: got %b want %b", req_ready, ~rst);
        end
        checks++;
        if (resp_valid !== exp_valid) begin
            failures++;
            $display("FAIL resp_valid: got %b want %b at %0t", resp_valid, exp_valid, $time);
        end
        if (exp_valid) begin
            checks++;
            if (resp_rdata !== cur.rdata || resp_err !== cur.err) begin
                failures++;
                $display("FAIL resp_model: got rdata=%h err=%b want rdata=%h err=%b at %0t",
                         resp_rdata, resp_err, cur.rdata, cur.err, $time);
            end
            if (cur.has_lit) begin
                checks++;
                if (resp_rdata !== cur.lit || resp_err !== cur.lit_err) begin
                    failures++;
                    $display("FAIL resp_literal: got rdata=%h err=%b want rdata=%h err=%b at %0t",
                             resp_rdata, resp_err, cur.lit, cur.lit_err, $time);
                end
            end
        end else begin
            checks++;
            if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
                failures++;
                $display("FAIL idle_outputs: got rdata=%h err=%b want rdata=0 err=0",
                         resp_rdata, resp_err);
            end
        end
    end

    // Drive one request right after a rising edge and predict its response.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic has_lit, input logic [31:0] lit, input logic lit_err);
        exp_t        e;
        logic [31:0] off;
        logic [31:0] w;
        int          n;
        @(posedge clk);
        #1;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        if (!rst) begin
            off   = addr - BASE;
            n     = 1 << size;
            e.err = (size == 2'd3) || (off >= (32'd1 << AW)) || ((off % n) != 0);
            w     = 32'h0;
            if (!e.err) begin
                if (we) begin
                    for (int i = 0; i < n; i++) mmem[int'(off) + i] = wdata[8*i +: 8];
                end else begin
                    for (int i = 0; i < n; i++)
                        w[8*i +: 8] = mmem.exists(int'(off) + i) ? mmem[int'(off) + i] : 8'h00;
                    if (n < 4 && !uns && w[8*n-1]) w = w | ~((32'd1 << (8*n)) - 32'd1);
                end
            end
            e.rdata   = (e.err || we) ? 32'h0 : w;
            e.has_lit = has_lit;
            e.lit     = lit;
            e.lit_err = lit_err;
            expq.push_back(e);
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        idle(3);
        @(posedge clk); #1; rst = 1'b0;
        idle(2);

        // word store / load and sub-word extraction
        issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1'b1, 32'hFFFFFFDE, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1'b1, 32'h000000DE, 1'b0);
        issue(1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 1'b1, 32'hFFFFBEEF, 1'b0);
        issue(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 1'b1, 32'h0000DEAD, 1'b0);
        // byte store into lane 1
        issue(1'b1, 2'd0, 1'b0, 32'h101, 32'h00000012, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEAD12EF, 1'b0);
        idle(1);
        // misaligned / reserved
        issue(1'b1, 2'd1, 1'b0, 32'h101, 32'h00005555, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEAD12EF, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1'b1);
        issue(1'b1, 2'd3, 1'b0, 32'h100, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEAD12EF, 1'b0);
        // half store in upper half, signed half load
        issue(1'b1, 2'd1, 1'b0, 32'h102, 32'h00008001, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 1'b1, 32'hFFFF8001, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, 32'h800112EF, 1'b0);
        // out of range, no wrap onto word 0
        issue(1'b1, 2'd2, 1'b0, 32'h0, 32'h0BADF00D, 1'b1, 32'h0, 1'b0);
        issue(1'b1, 2'd2, 1'b0, 32'h00040000, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h00040000, 32'h0, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0BADF00D, 1'b0);
        idle(2);
        // back-to-back stream
        issue(1'b1, 2'd2, 1'b0, 32'h200, 32'h11111111, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 1'b1, 32'h11111111, 1'b0);
        issue(1'b1, 2'd2, 1'b0, 32'h200, 32'h22222222, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 1'b1, 32'h22222222, 1'b0);
        // reset while that load's response is due; a store presented in reset must not land
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
        req_addr = 32'h200; req_wdata = 32'h33333333;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        idle(1);
        issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 1'b1, 32'h22222222, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'h201, 32'h0, 1'b1, 32'h00000022, 1'b0);
        idle(3);

        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d outstanding want 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
